dct_quant: RTL
==============

Name: dct_quant

Overview:
- Pipelined quantizer directly downstream of dct_ft.
- Consumes one row of 8 signed DCT coefficients per valid beat, 8 rows per 8x8 block.
- Multiplies each coefficient by a per-position reciprocal quantization factor, rounds, saturates, and forwards the result to the entropy/zigzag stage.
- Block/frame markers (eob/sob/sof) pass through aligned with the data.

Parameters:
- W_I, 16, signed input coefficient width per lane (matches dct_ft output).
- W_O, 12, signed output coefficient width per lane.
- W_R, 16, unsigned reciprocal table entry width; entry = round(65536/Q), Q=1 stored as 65535.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  input row beat valid; no backpressure, accepted every cycle it is high.
- in_data  in  8xW_I  signed coefficients; lane i = column i of current row.
- in_eob  in  1  last row of block.
- in_sob  in  1  first row of block.
- in_sof  in  1  first row of frame (only with in_sob).
- out_valid  out  1  output row valid.
- out_data  out  8xW_O  quantized signed coefficients; lane i = column i.
- out_eob  out  1  delayed in_eob.
- out_sob  out  1  delayed in_sob.
- out_sof  out  1  delayed in_sof.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous, active-low.
- Reset values: out_valid=0, out_eob=0, out_sob=0, out_sof=0, out_data=0, row counter=0, all pipeline valids=0.
- Latency: exactly 2 cycles from accepted input to out_valid. Throughput is 1 row/cycle, and gaps pass through unchanged.
- Row index:
  - row = in_sob ? 0 : row_cnt.
  - On each accepted beat, row_cnt <= (row+1) mod 8.
  - in_sob mid-block forces row 0; no error flag.
  - Beats beyond 8 without sob wrap to row 0.
- Stage 1: prod[i] = in_data[i] (signed) * tbl[row*8+i] (unsigned, zero-extended). Full W_I+W_R+1 bit signed product. Register prod, ctrl, and valid.
- Stage 2:
  - r = (prod + 2^15) >>> 16, arithmetic shift, i.e. round half up.
  - Saturate r to [-2^(W_O-1), 2^(W_O-1)-1]. Register into out_data along with ctrl and valid.
- Ctrl bits are registered alongside valid regardless of valid. out_* are meaningful only when out_valid=1, and are 0 otherwise (gated).
- Default table: JPEG Annex K luminance table (quality 50), row-major, converted to reciprocals at elaboration. Row 0 Q = 16 11 10 16 24 40 51 61.
- Reset mid-block: the pipeline is flushed (in-flight rows are lost), and the next beat uses row 0 if it has sob, else row_cnt=0.

Optional Feature:
- Macro: DCT_QUANT_TABLE_LOAD_EN.
- With the macro, three extra input ports are added:
  - tbl_wr_en (1)
  - tbl_wr_addr (6)
  - tbl_wr_data (W_R)
- Writes go to a shadow table.
- The shadow is copied to the active table on an accepted beat with in_sof=1. That beat already uses the new active table (copy is combinationally visible to stage 1, registered for later rows).
- A write in the same cycle as the sof copy is applied to the shadow after the copy and takes effect at the next frame.
- Reset restores both tables to the default table.
- Without the macro: no extra ports, and the active table is a constant default table.

Test Plan:
- Reset, then one block with all lanes = 1000 and sob on row 0:
  - Row 0 outputs are 63,91,100,63,42,25,20,16.
  - out_valid rises exactly 2 cycles after in_valid.
  - out_eob is on the 8th output row.
- Lane 0 row 0 = -1000, sof=1 -> out_data[0] = -62 (round half up), out_sof=1, out_sob=1.
- Row 0 lane 2 = 32767 -> 2047 (saturated). Lane 2 = -32768 -> -2048.
- Random gaps of 1-36 idle cycles between blocks, plus a second in_sob after 3 rows:
  - Row index restarts at 0.
  - Output ordering and ctrl are identical to the input, shifted by 2 cycles.
  - No valid is dropped or duplicated.
- rst_n low for 1 cycle during row 4 of a block -> out_valid=0 for the 2 following cycles. The next sob block quantizes with row 0 factors.
- (DCT_QUANT_TABLE_LOAD_EN) Write addr 0 = 65535, then send a sob block without sof:
  - Lane 0 still uses Q=16.
  - Next sof block with lane 0 = 100 gives output 100.
  - A write in the same cycle as sof is not visible until the following sof.

Source files
------------

// File: rtl/dct_quant.sv
// dct_quant: two-stage reciprocal quantizer for 8-lane DCT rows.
// Define DCT_QUANT_TABLE_LOAD_EN for a frame-synchronous table load port.
module dct_quant #(
  parameter int W_I = 16,
  parameter int W_O = 12,
  parameter int W_R = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [8*W_I-1:0]   in_data,
  input  logic               in_eob,
  input  logic               in_sob,
  input  logic               in_sof,
`ifdef DCT_QUANT_TABLE_LOAD_EN
  input  logic               tbl_wr_en,
  input  logic [5:0]         tbl_wr_addr,
  input  logic [W_R-1:0]     tbl_wr_data,
`endif
  output logic               out_valid,
  output logic [8*W_O-1:0]   out_data,
  output logic               out_eob,
  output logic               out_sob,
  output logic               out_sof
);

  localparam int WP = W_I + W_R + 1;
  localparam int WS = WP + 1;

  localparam logic signed [WS-1:0] MAXV = WS'(2**(W_O-1) - 1);
  localparam logic signed [WS-1:0] MINV = WS'(-(2**(W_O-1)));
  localparam logic signed [WS-1:0] RND  = WS'(32768);

  localparam int QTAB [64] = '{
    16, 11, 10, 16, 24, 40, 51, 61,
    12, 12, 14, 19, 26, 58, 60, 55,
    14, 13, 16, 24, 40, 57, 69, 56,
    14, 17, 22, 29, 51, 87, 80, 62,
    18, 22, 37, 56, 68,109,103, 77,
    24, 35, 55, 64, 81,104,113, 92,
    49, 64, 78, 87,103,121,120,101,
    72, 92, 95, 98,112,100,103, 99
  };

  // Q=1 would need 65536, which does not fit; saturate to all-ones.
  function automatic logic [W_R-1:0] recip(int q);
    if (q == 1) return '1;
    return W_R'((131072 + q) / (2 * q));
  endfunction

  logic [W_R-1:0] def_tbl [64];
  logic [W_R-1:0] tbl [64];

  for (genvar g = 0; g < 64; g++) begin : g_def
    assign def_tbl[g] = recip(QTAB[g]);
  end

`ifdef DCT_QUANT_TABLE_LOAD_EN
  logic [W_R-1:0] sh_q  [64];
  logic [W_R-1:0] act_q [64];
  logic           sof_cp;

  assign sof_cp = in_valid & in_sof;

  // The sof beat already sees the shadow contents.
  always_comb begin
    for (int k = 0; k < 64; k++) begin
      tbl[k] = sof_cp ? sh_q[k] : act_q[k];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 64; k++) begin
        sh_q[k]  <= def_tbl[k];
        act_q[k] <= def_tbl[k];
      end
    end else begin
      if (sof_cp) begin
        for (int k = 0; k < 64; k++) begin
          act_q[k] <= sh_q[k];
        end
      end
      if (tbl_wr_en) begin
        sh_q[tbl_wr_addr] <= tbl_wr_data;
      end
    end
  end
`else
  always_comb begin
    for (int k = 0; k < 64; k++) begin
      tbl[k] = def_tbl[k];
    end
  end
`endif

  logic [2:0] row_cnt_q, row_cnt_d, row;

  assign row = in_sob ? 3'd0 : row_cnt_q;

  always_comb begin
    row_cnt_d = row_cnt_q;
    if (in_valid) row_cnt_d = row + 3'd1;
  end

  logic signed [WP-1:0] prod_d [8];
  logic signed [WP-1:0] prod_q [8];
  logic                 v1_q;
  logic [2:0]           c1_q;

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      prod_d[i] = WP'($signed(in_data[i*W_I +: W_I]))
                * WP'($signed({1'b0, tbl[{row, 3'(i)}]}));
    end
  end

  logic signed [WS-1:0] sum [8];
  logic signed [WS-1:0] shr [8];
  logic [8*W_O-1:0]     data_d;

  // Round half up, then clamp to the output range.
  always_comb begin
    data_d = '0;
    for (int i = 0; i < 8; i++) begin
      sum[i] = WS'(prod_q[i]) + RND;
      shr[i] = sum[i] >>> 16;
      if (shr[i] > MAXV) begin
        data_d[i*W_O +: W_O] = MAXV[W_O-1:0];
      end else if (shr[i] < MINV) begin
        data_d[i*W_O +: W_O] = MINV[W_O-1:0];
      end else begin
        data_d[i*W_O +: W_O] = shr[i][W_O-1:0];
      end
    end
  end

  logic               v2_q;
  logic [2:0]         c2_q;
  logic [8*W_O-1:0]   data_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row_cnt_q <= '0;
      v1_q      <= 1'b0;
      c1_q      <= '0;
      v2_q      <= 1'b0;
      c2_q      <= '0;
      data_q    <= '0;
      for (int i = 0; i < 8; i++) prod_q[i] <= '0;
    end else begin
      row_cnt_q <= row_cnt_d;
      v1_q      <= in_valid;
      c1_q      <= {in_sof, in_sob, in_eob};
      v2_q      <= v1_q;
      c2_q      <= c1_q;
      data_q    <= data_d;
      for (int i = 0; i < 8; i++) prod_q[i] <= prod_d[i];
    end
  end

  assign out_valid = v2_q;
  assign out_data  = v2_q ? data_q : '0;
  assign out_eob   = v2_q & c2_q[0];
  assign out_sob   = v2_q & c2_q[1];
  assign out_sof   = v2_q & c2_q[2];

endmodule
